// File: rtl/debounce_pkg.sv
// debounce_pkg: debouncer channel FSM state type and default TICK_DIV/STABLE_CNT constants
package debounce_pkg;
  typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} db_state_t;
  localparam int TICK_DIV_DEF = 4;
  localparam int STABLE_CNT_DEF = 3;
endpackage

// File: rtl/debounce_tick_gen.sv
// debounce_tick_gen: prescaler pulsing tick for one cycle every TICK_DIV clk cycles; ports clk, reset (async active-low), tick
module debounce_tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: per-channel switch debouncer with round-robin event arbiter; ports clk, reset (async active-low), q raw in, Q debounced, ev_valid/ev_ready/ev_chan/ev_level handshake, ev_lost sticky; macro DEBOUNCE_RELEASE_EV_EN adds release events
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         q,
  output logic [N_CH-1:0]         Q,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(N_CH)-1:0] ev_chan,
  output logic                    ev_level,
  output logic                    ev_lost
);
  localparam int CW = $clog2(N_CH);
  localparam int SW = $clog2(STABLE_CNT);
`ifdef DEBOUNCE_RELEASE_EV_EN
  localparam bit REL_EV = 1'b1;
`else
  localparam bit REL_EV = 1'b0;
`endif
  logic tick, gnt, lost_n;
  logic [N_CH-1:0] s1, s2, rise, fall, ev_edge, pend, pend_n, lvl, lvl_n;
  logic [CW-1:0] ptr, gidx;
  db_state_t st [N_CH];
  db_state_t st_n [N_CH];
  logic [SW-1:0] cnt [N_CH];
  logic [SW-1:0] cnt_n [N_CH];

  function automatic logic [CW-1:0] wrap(input int v);
    return CW'(v >= N_CH ? v - N_CH : v);
  endfunction

  debounce_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));

  assign ev_edge = rise | (REL_EV ? fall : '0);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_n[i] = st[i];
      cnt_n[i] = cnt[i];
      rise[i] = 1'b0;
      fall[i] = 1'b0;
      Q[i] = st[i] == IDLE_HI || st[i] == CHK_LO;
      if (tick)
        case (st[i])
          IDLE_LO: if (s2[i]) begin
            st_n[i] = CHK_HI;
            cnt_n[i] = SW'(1);
          end
          IDLE_HI: if (!s2[i]) begin
            st_n[i] = CHK_LO;
            cnt_n[i] = SW'(1);
          end
          default: if (s2[i] != (st[i] == CHK_HI)) begin
            st_n[i] = st[i] == CHK_HI ? IDLE_LO : IDLE_HI;
            cnt_n[i] = '0;
          end else if (cnt[i] == SW'(STABLE_CNT - 1)) begin
            st_n[i] = st[i] == CHK_HI ? IDLE_HI : IDLE_LO;
            cnt_n[i] = '0;
            rise[i] = st[i] == CHK_HI;
            fall[i] = st[i] == CHK_LO;
          end else cnt_n[i] = cnt[i] + 1'b1;
        endcase
    end
  end

  always_comb begin
    gnt = 1'b0;
    gidx = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (!ev_valid && pend[wrap(int'(ptr) + k)]) begin
        gnt = 1'b1;
        gidx = wrap(int'(ptr) + k);
      end
    pend_n = pend;
    lvl_n = lvl;
    lost_n = ev_lost;
    if (gnt) pend_n[gidx] = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (ev_edge[i]) begin
        lost_n = lost_n | (pend[i] & ~(gnt && gidx == CW'(i)));
        pend_n[i] = 1'b1;
        lvl_n[i] = rise[i];
      end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      pend <= '0;
      lvl <= '0;
      ptr <= '0;
      ev_valid <= 1'b0;
      ev_chan <= '0;
      ev_level <= 1'b0;
      ev_lost <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        st[i] <= IDLE_LO;
        cnt[i] <= '0;
      end
    end else begin
      s1 <= q;
      s2 <= s1;
      pend <= pend_n;
      lvl <= lvl_n;
      ev_lost <= lost_n;
      st <= st_n;
      cnt <= cnt_n;
      if (gnt) begin
        ev_valid <= 1'b1;
        ev_chan <= gidx;
        ev_level <= lvl[gidx];
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
        ptr <= wrap(int'(ev_chan) + 1);
      end
    end
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb_debounce_scan_ctrl: table, directed and random checks of debounce_scan_ctrl against a run-length debounce model
module tb_debounce_scan_ctrl;
  localparam int N = 4, TD = 4, SC = 3;
`ifdef DEBOUNCE_RELEASE_EV_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  typedef struct {int c; logic l;} ev_t;
  typedef struct {logic [3:0] qv; int hold; logic [3:0] eq;} vec_t;
  logic clk = 1'b0, rst_n = 1'b1, ev_ready = 1'b1;
  logic ev_valid, ev_level, ev_lost;
  logic [N-1:0] q = '0, Q;
  logic [1:0] ev_chan;
  int errors = 0, checks = 0;
  logic [N-1:0] sy1, sy2, mq, q0;
  int pre;
  int run [N];
  int ecnt [N];
  int acnt [N];
  bit track = 1'b0;
  ev_t acc[$];
  ev_t exq[$];
  vec_t tbl [9];

  always #5 clk = ~clk;

  debounce_scan_ctrl #(.N_CH(N), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clk(clk), .reset(rst_n), .q(q), .Q(Q), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_chan(ev_chan), .ev_level(ev_level), .ev_lost(ev_lost));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ev_t mk(input int c, input logic l);
    ev_t e;
    e.c = c;
    e.l = l;
    return e;
  endfunction

  task automatic mreset();
    sy1 = '0;
    sy2 = '0;
    mq = '0;
    pre = 0;
    for (int c = 0; c < N; c++) run[c] = 0;
  endtask

  task automatic cyc();
    if (ev_valid && ev_ready && rst_n) begin
      acc.push_back(mk(int'(ev_chan), ev_level));
      if (track) begin
        chk("ev_has_edge", acnt[ev_chan] < ecnt[ev_chan], 1);
        chk("ev_level_seq", ev_level, REL ? (~q0[ev_chan]) ^ acnt[ev_chan][0] : 1'b1);
        acnt[ev_chan]++;
      end
    end
    if (!rst_n) mreset();
    else begin
      if (pre == TD - 1)
        for (int c = 0; c < N; c++)
          if (sy2[c] != mq[c]) begin
            run[c]++;
            if (run[c] == SC) begin
              mq[c] = sy2[c];
              run[c] = 0;
              if (track && (REL || mq[c])) ecnt[c]++;
            end
          end else run[c] = 0;
      pre = pre == TD - 1 ? 0 : pre + 1;
      sy2 = sy1;
      sy1 = q;
    end
    @(posedge clk);
    #1;
    chk("Q_model", Q, mq);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q = '0;
    ev_ready = 1'b1;
    mreset();
    cyc();
    cyc();
    rst_n = 1'b1;
    acc.delete();
  endtask

  task automatic start_track();
    for (int c = 0; c < N; c++) begin
      ecnt[c] = 0;
      acnt[c] = 0;
    end
    q0 = mq;
    track = 1'b1;
  endtask

  task automatic end_track();
    for (int c = 0; c < N; c++) chk($sformatf("ev_count_ch%0d", c), acnt[c], ecnt[c]);
    chk("ev_lost_clear", ev_lost, 0);
    track = 1'b0;
  endtask

  task automatic expect_events(input string nm);
    chk({nm, "_count"}, acc.size(), exq.size());
    for (int i = 0; i < exq.size() && i < acc.size(); i++) begin
      chk($sformatf("%s_chan%0d", nm, i), acc[i].c, exq[i].c);
      chk($sformatf("%s_level%0d", nm, i), acc[i].l, exq[i].l);
    end
  endtask

  initial begin
    bit found;
    int hi, vc;
    tbl = '{'{4'b0001, 24, 4'b0001}, '{4'b0011, 24, 4'b0011}, '{4'b0010, 24, 4'b0010},
            '{4'b1010, 2, 4'b0010}, '{4'b0010, 24, 4'b0010}, '{4'b0000, 3, 4'b0010},
            '{4'b0010, 24, 4'b0010}, '{4'b1111, 24, 4'b1111}, '{4'b0000, 24, 4'b0000}};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_Q", Q, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_chan", ev_chan, 0);
    chk("rst_level", ev_level, 0);
    chk("rst_lost", ev_lost, 0);
    do_reset();
    start_track();
    for (int i = 0; i < 9; i++) begin
      q = tbl[i].qv;
      repeat (tbl[i].hold) cyc();
      chk($sformatf("tbl%0d_Q", i), Q, tbl[i].eq);
    end
    repeat (12) cyc();
    end_track();
    start_track();
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(15) == 0) q[c] = ~q[c];
      cyc();
    end
    repeat (30) cyc();
    end_track();
    do_reset();
    q = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      found = Q[0];
    end
    chk("r31_q0_rise", found, 1);
    chk("r31_valid_not_yet", ev_valid, 0);
    cyc();
    chk("r31_valid", ev_valid, 1);
    chk("r31_chan", ev_chan, 0);
    chk("r31_level", ev_level, 1);
    repeat (3) cyc();
    chk("r31_single", acc.size(), 1);
    do_reset();
    hi = 0;
    vc = 0;
    for (int i = 0; i < 60; i++) begin
      if (i < 40 && i % 5 == 0) q[1] = ~q[1];
      cyc();
      hi += int'(Q[1]);
      vc += int'(ev_valid);
    end
    chk("r32_Q1_high", hi, 0);
    chk("r32_events", vc, 0);
    do_reset();
    q = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      found = ev_valid;
    end
    chk("r33_first", found, 1);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("r33_valid%0d", k), ev_valid, k % 2 == 0);
      if (k % 2 == 0) begin
        chk($sformatf("r33_chan%0d", k), ev_chan, k / 2);
        chk($sformatf("r33_level%0d", k), ev_level, 1);
      end
      cyc();
    end
    do_reset();
    ev_ready = 1'b0;
    q[2] = 1'b1;
    repeat (40) cyc();
    q[2] = 1'b0;
    repeat (40) cyc();
    chk("r34_lost", ev_lost, 0);
    acc.delete();
    exq.delete();
    exq.push_back(mk(2, 1'b1));
    if (REL) exq.push_back(mk(2, 1'b0));
    ev_ready = 1'b1;
    repeat (10) cyc();
    expect_events("r34");
    do_reset();
    ev_ready = 1'b0;
    q[3] = 1'b1;
    repeat (40) cyc();
    q[3] = 1'b0;
    repeat (40) cyc();
    q[3] = 1'b1;
    repeat (40) cyc();
    chk("r35_lost", ev_lost, REL);
    acc.delete();
    exq.delete();
    exq.push_back(mk(3, 1'b1));
    exq.push_back(mk(3, 1'b1));
    ev_ready = 1'b1;
    repeat (10) cyc();
    expect_events("r35");
    do_reset();
    ev_ready = 1'b0;
    q = 4'b0010;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      found = ev_valid;
    end
    chk("r36_valid_up", found, 1);
    q[0] = 1'b1;
    repeat (7) cyc();
    chk("r36_pre_Q0", Q[0], 0);
    chk("r36_pre_chan", ev_chan, 1);
    #2 rst_n = 1'b0;
    mreset();
    #1;
    chk("r36_Q", Q, 0);
    chk("r36_valid", ev_valid, 0);
    chk("r36_chan", ev_chan, 0);
    chk("r36_level", ev_level, 0);
    chk("r36_lost", ev_lost, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    ev_ready = 1'b1;
    acc.delete();
    repeat (40) cyc();
    exq.delete();
    exq.push_back(mk(0, 1'b1));
    exq.push_back(mk(1, 1'b1));
    expect_events("r36");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/debounce_scan_ctrl.md
DEBOUNCE_SCAN_CTRL -- requirements
Module: debounce_scan_ctrl

Interface
REQ-001 Parameter: N_CH, 4, number of switch channels (2..16).
REQ-002 Parameter: TICK_DIV, 4, clk cycles per sample tick (>=2).
REQ-003 Parameter: STABLE_CNT, 3, consecutive equal samples needed to accept a new level (>=2).
REQ-004 Port: clk  input  1  rising-edge system clock.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: q  input  N_CH  raw, asynchronous switch inputs.
REQ-007 Port: Q  output  N_CH  debounced levels.
REQ-008 Port: ev_valid  output  1  event available.
REQ-009 Port: ev_ready  input  1  consumer accepts event.
REQ-010 Port: ev_chan  output  clog2(N_CH)  channel of presented event.
REQ-011 Port: ev_level  output  1  new debounced level of that channel.
REQ-012 Port: ev_lost  output  1  sticky flag: an event was dropped.

Function
REQ-013 Each q bit SHALL pass a 2-flop synchronizer before any use.
REQ-014 One shared tick SHALL pulse for one cycle when the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
REQ-015 Per channel, the FSM {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} SHALL advance only on tick cycles.
REQ-016 IDLE_LO: synced 1 -> CHK_HI, cnt=1. IDLE_HI: synced 0 -> CHK_LO, cnt=1.
REQ-017 CHK_HI: synced 1 and cnt==STABLE_CNT-1 -> IDLE_HI, Q=1, edge; synced 1 otherwise -> cnt+1; synced 0 -> IDLE_LO, cnt=0, no edge. CHK_LO is symmetric.
REQ-018 An edge SHALL set the channel's pending flag and stored level in the same cycle Q changes.
REQ-019 If pending is already set when an edge occurs, the stored level SHALL be overwritten, pending stays set, and ev_lost SHALL set.
REQ-020 When ev_valid is 0, the next cycle SHALL grant the first pending channel at or after the round-robin pointer, load ev_chan/ev_level, assert ev_valid, and clear that pending flag.
REQ-021 While ev_valid=1 and ev_ready=0, ev_chan and ev_level SHALL stay constant.
REQ-022 On ev_valid&ev_ready, ev_valid SHALL drop next cycle and the pointer SHALL become (ev_chan+1) mod N_CH; peak rate is one event per 2 cycles.
REQ-023 An edge on the channel currently presented SHALL re-set pending, not modify the held outputs, and not set ev_lost.
REQ-024 Edge-to-ev_valid latency SHALL be 1 cycle when idle.

Reset
REQ-025 reset low SHALL immediately force Q=0, ev_valid=0, ev_chan=0, ev_level=0, ev_lost=0, all FSMs to IDLE_LO, counters, prescaler, synchronizers, pending flags and pointer to 0, including mid-check or mid-handshake.

Configuration
REQ-026 Macro DEBOUNCE_RELEASE_EV_EN defined: both 0->1 and 1->0 edges generate events.
REQ-027 Macro not defined: only 0->1 edges set pending, Q still tracks both directions, and release never sets ev_lost.

Structure
REQ-028 Package debounce_pkg SHALL hold the FSM state enum and the default TICK_DIV/STABLE_CNT constants.
REQ-029 The prescaler SHALL be a sub-module debounce_tick_gen; the channel FSMs, pending logic and arbiter stay in debounce_scan_ctrl.

Verification
REQ-030 Verification settings: N_CH=4, TICK_DIV=4, STABLE_CNT=3, ev_ready=1 unless stated.
REQ-031 q[0] steps 0->1 and holds -> Q[0]=1 on the 3rd tick after synced high; one event chan=0, level=1.
REQ-032 q[1] toggles every 5 cycles for 40 cycles then stays 0 -> Q[1]=0 throughout; no event.
REQ-033 q[3:0]=4'hF in one cycle -> events on chan 0,1,2,3 in order, ev_valid high every other cycle.
REQ-034 Hold ev_ready=0; q[2] press, then release after 40 cycles; then set ev_ready=1 -> with macro, events (2,1) then (2,0) and ev_lost=0; without macro, only (2,1).
REQ-035 With macro and ev_ready=0; q[3] press, release, press (each stable 40 cycles) -> ev_lost=1; after ev_ready=1, events (3,1) then (3,1).
REQ-036 Assert reset while ch0 is in CHK_HI and ev_valid=1 -> all outputs 0 in the same cycle; after release, the next grant starts from chan 0.
